// File: rtl/tx_pixel_fetch.sv
// Pixel prefetch ahead of the HDMI timing stage: streams one frame from the frame store
// through a credit-limited request port into a show-ahead FIFO, and toggles frame parity per frame.
module tx_pixel_fetch #(
  parameter int                H_ACTIVE  = 640,
  parameter int                V_ACTIVE  = 480,
  parameter int                ADDR_W    = 19,
  parameter int                DEPTH     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_vsync,
  input  logic              pix_read,
  output logic [23:0]       pix_data,
  output logic              frame_sync,
  output logic              underflow,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [23:0]       mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic              vs_q;
  logic [1:0]        state_q,      state_d;
  logic [CNT_W-1:0]  level_q,      level_d;
  logic [CNT_W-1:0]  out_q,        out_d;
  logic [ADDR_W-1:0] issued_q,     issued_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
  logic              frame_sync_q, frame_sync_d;
  logic              underflow_q,  underflow_d;

  logic [23:0] fifo_mem [DEPTH];

  logic frame_start;
  logic credit_ok;
  logic accept;
  logic ret;
  logic push;
  logic pop;

  assign frame_start = vs_q & ~pix_vsync;

  // Reads in flight are counted against FIFO space so a push can never hit a full FIFO.
  assign credit_ok = ({1'b0, level_q} + {1'b0, out_q}) < DEPTH_C;
  assign mem_req   = (state_q == S_FETCH) && credit_ok;
  assign accept    = mem_req & mem_ack;

  // A beat with nothing outstanding is a protocol error and is dropped outright.
  assign ret  = mem_rvalid & (out_q != '0);
  assign push = ret & (state_q != S_FLUSH);
  assign pop  = pix_read & (level_q != '0);

  assign mem_addr   = addr_q;
  assign frame_sync = frame_sync_q;
  assign underflow  = underflow_q;
  assign pix_data   = (level_q != '0) ? fifo_mem[rd_ptr_q] : 24'h000000;

  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    addr_d       = addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frame_sync_d = frame_sync_q;
    underflow_d  = underflow_q;

    if (accept) begin
      addr_d   = addr_q + 1'b1;
      issued_d = issued_q + 1'b1;
    end

    out_d   = out_q + CNT_W'(accept) - CNT_W'(ret);
    level_d = level_q + CNT_W'(push) - CNT_W'(pop);

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (pix_read && (level_q == '0)) underflow_d = 1'b1;

    case (state_q)
      S_FETCH: if (accept && (issued_q == LAST_IDX)) state_d = S_DONE;
      S_FLUSH: if (out_d == '0) state_d = S_FETCH;
      default: ;
    endcase

    // A new frame overrides everything; reads already in flight for the old frame
    // (including one accepted this very cycle) must drain before fetching restarts.
    if (frame_start) begin
      level_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      addr_d       = BASE_ADDR;
      issued_d     = '0;
      frame_sync_d = ~frame_sync_q;
      underflow_d  = 1'b0;
      state_d      = (out_d == '0) ? S_FETCH : S_FLUSH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q         <= 1'b1;
      state_q      <= S_IDLE;
      level_q      <= '0;
      out_q        <= '0;
      issued_q     <= '0;
      addr_q       <= BASE_ADDR;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_sync_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      vs_q         <= pix_vsync;
      state_q      <= state_d;
      level_q      <= level_d;
      out_q        <= out_d;
      issued_q     <= issued_d;
      addr_q       <= addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_sync_q <= frame_sync_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage needs no reset: contents are only visible through level_q.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rdata;
  end

endmodule

// File: tb/tb_tx_pixel_fetch.sv
// Directed bench for tx_pixel_fetch on a reduced 16x4 frame with an in-order,
// fixed-latency memory responder.
module tb_tx_pixel_fetch;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int AW = 8;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_vsync;
  logic          pix_read;
  logic [23:0]   pix_data;
  logic          frame_sync;
  logic          underflow;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [23:0]   mem_rdata;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  int lat    = 3;
  int n;
  int q_addr[$];
  int q_due[$];

  always #5 clk = ~clk;

  tx_pixel_fetch #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW),
    .DEPTH    (D),
    .BASE_ADDR(8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_vsync (pix_vsync),
    .pix_read  (pix_read),
    .pix_data  (pix_data),
    .frame_sync(frame_sync),
    .underflow (underflow),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs and the memory response at the falling edge,
  // then log any accepted request so its data returns lat cycles later.
  task automatic cycle_in(input logic vs, input logic rd, input logic ack);
    @(negedge clk);
    cyc++;
    pix_vsync = vs;
    pix_read  = rd;
    mem_ack   = ack;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 24'hA00000 | 24'(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 24'h5A5A5A;
    end
    #1;
    if (mem_req && mem_ack) begin
      q_addr.push_back(int'(mem_addr));
      q_due.push_back(cyc + lat);
    end
  endtask

  // Pops a full frame (FIFO pre-filled), expecting data tagged with addresses 0..H*V-1.
  task automatic drain_frame(input string tag);
    for (int i = 0; i < H * V; i++) begin
      cycle_in(1'b1, 1'b1, 1'b1);
      chk($sformatf("%s_pix%0d", tag, i), pix_data, 24'hA00000 | 24'(i));
    end
    cycle_in(1'b1, 1'b0, 1'b1);
    chk({tag, "_empty_data"}, pix_data, 24'h000000);
    chk({tag, "_no_underflow"}, underflow, 1'b0);
    chk({tag, "_done_req"}, mem_req, 1'b0);
    chk({tag, "_done_addr"}, mem_addr, 8'd64);
    repeat (5) cycle_in(1'b1, 1'b0, 1'b1);
    chk({tag, "_done_hold"}, mem_req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pix_vsync = 1'b1; pix_read = 1'b0;
    mem_ack = 1'b1; mem_rvalid = 1'b0; mem_rdata = 24'h0;
    repeat (3) cycle_in(1'b1, 1'b0, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'd0);
    chk("rst_pix_data", pix_data, 24'h0);
    chk("rst_frame_sync", frame_sync, 1'b0);
    chk("rst_underflow", underflow, 1'b0);
    rst = 1'b0;

    repeat (4) cycle_in(1'b1, 1'b0, 1'b1);
    chk("idle_no_req", mem_req, 1'b0);

    // Frame 1: latency 3, ack high, fill until credit runs out.
    cycle_in(1'b0, 1'b0, 1'b1);
    chk("f1_start_no_req", mem_req, 1'b0);
    cycle_in(1'b1, 1'b0, 1'b1);
    chk("f1_req_rise", mem_req, 1'b1);
    chk("f1_addr0", mem_addr, 8'd0);
    chk("f1_frame_sync", frame_sync, 1'b1);
    cycle_in(1'b1, 1'b0, 1'b1);
    chk("f1_addr1", mem_addr, 8'd1);
    cycle_in(1'b1, 1'b0, 1'b1);
    chk("f1_addr2", mem_addr, 8'd2);
    for (int k = 4; k <= 25; k++) cycle_in(1'b1, 1'b0, 1'b1);
    chk("f1_credit_stall", mem_req, 1'b0);
    chk("f1_stall_addr", mem_addr, 8'd16);
    chk("f1_head", pix_data, 24'hA00000);
    drain_frame("f1");

    // Frame 2: long latency, pop on empty, then only 5 reads outstanding.
    cycle_in(1'b0, 1'b0, 1'b0);
    lat = 40;
    cycle_in(1'b1, 1'b1, 1'b1);
    chk("f2_empty_data", pix_data, 24'h0);
    chk("f2_req", mem_req, 1'b1);
    chk("f2_frame_sync", frame_sync, 1'b0);
    cycle_in(1'b1, 1'b0, 1'b1);
    chk("f2_underflow_set", underflow, 1'b1);
    repeat (3) cycle_in(1'b1, 1'b0, 1'b1);
    repeat (3) cycle_in(1'b1, 1'b0, 1'b0);
    chk("f2_hold_req", mem_req, 1'b1);
    chk("f2_hold_addr", mem_addr, 8'd5);
    chk("f2_underflow_sticky", underflow, 1'b1);
    chk("f2_still_empty", pix_data, 24'h0);
    cycle_in(1'b1, 1'b0, 1'b0);

    // Frame 3 starts with 5 reads in flight: they must be flushed.
    cycle_in(1'b0, 1'b0, 1'b0);
    lat = 3;
    cycle_in(1'b1, 1'b0, 1'b1);
    chk("f3_flush_no_req", mem_req, 1'b0);
    chk("f3_addr_reset", mem_addr, 8'd0);
    chk("f3_frame_sync", frame_sync, 1'b1);
    chk("f3_underflow_clr", underflow, 1'b0);
    chk("f3_level0", pix_data, 24'h0);
    n = 1;
    while (mem_req !== 1'b1 && n < 100) begin
      cycle_in(1'b1, 1'b0, 1'b1);
      n++;
    end
    chk("f3_flush_len", n, 36);
    chk("f3_restart_addr", mem_addr, 8'd0);
    chk("f3_dropped", pix_data, 24'h0);
    repeat (24) cycle_in(1'b1, 1'b0, 1'b1);
    drain_frame("f3");

    // Frame 4 checks parity, frame 5 builds level 9 with underflow set.
    cycle_in(1'b0, 1'b0, 1'b0);
    cycle_in(1'b1, 1'b0, 1'b0);
    chk("f4_frame_sync", frame_sync, 1'b0);
    chk("f4_req", mem_req, 1'b1);
    cycle_in(1'b1, 1'b0, 1'b0);
    cycle_in(1'b0, 1'b0, 1'b0);
    cycle_in(1'b1, 1'b1, 1'b1);
    chk("f5_frame_sync", frame_sync, 1'b1);
    repeat (8) cycle_in(1'b1, 1'b0, 1'b1);
    repeat (10) cycle_in(1'b1, 1'b0, 1'b0);
    chk("f5_lvl9_head", pix_data, 24'hA00000);
    chk("f5_lvl9_addr", mem_addr, 8'd9);
    chk("f5_underflow", underflow, 1'b1);

    // Asynchronous reset in the middle of a cycle.
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_req", mem_req, 1'b0);
    chk("arst_mem_addr", mem_addr, 8'd0);
    chk("arst_pix_data", pix_data, 24'h0);
    chk("arst_frame_sync", frame_sync, 1'b0);
    chk("arst_underflow", underflow, 1'b0);
    q_addr.delete();
    q_due.delete();
    mem_rvalid = 1'b0;
    #2 rst = 1'b0;
    repeat (8) cycle_in(1'b1, 1'b0, 1'b1);
    chk("post_rst_idle", mem_req, 1'b0);
    cycle_in(1'b0, 1'b0, 1'b1);
    cycle_in(1'b1, 1'b0, 1'b1);
    chk("post_rst_req", mem_req, 1'b1);
    chk("post_rst_addr", mem_addr, 8'd0);
    chk("post_rst_frame_sync", frame_sync, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
